// File: rtl/pll_lock_supervisor_pkg.sv
// Shared state encoding and counter sizing for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PWD    = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // Width of a counter that must reach (max of all durations) - 1; at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for signals asynchronous to clk.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Power-down / reset / lock-qualification sequencer for one GTP_GPLL.
// Define PLL_LOCK_SUPERVISOR_LOSS_CNT_EN to add the saturating loss_cnt output.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned PWD_CYCLES   = 16,
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 27000,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int unsigned CW = cnt_width(PWD_CYCLES, RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  localparam logic [CW-1:0] PWD_LAST     = CW'(PWD_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRY);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    retry_next;
  logic          lock_s;
  logic          lost;
  logic          pwd_next, prst_next, sys_next, ready_next, fail_next;

  sync_2ff u_lock_sync (
    .clk (clk),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_next = state;
    retry_next = retry_cnt;
    lost       = 1'b0;
    if (restart) begin
      state_next = ST_PWD;
      retry_next = '0;
    end else begin
      unique case (state)
        ST_PWD:    if (cnt == PWD_LAST) state_next = ST_RST;
        ST_RST:    if (cnt == RST_LAST) state_next = ST_WAIT;
        ST_WAIT: begin
          // Lock arriving on the timeout cycle takes precedence over the retry.
          if (lock_s) begin
            state_next = ST_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_next = ST_FAIL;
            end else begin
              retry_next = retry_cnt + 4'd1;
              state_next = ST_RST;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s)                 state_next = ST_WAIT;
          else if (cnt == STABLE_LAST) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_RST;
            retry_next = '0;
            lost       = 1'b1;
          end
        end
        ST_FAIL:   state_next = ST_FAIL;
        default:   state_next = ST_PWD;
      endcase
    end

    cnt_next = (restart || (state_next != state)) ? '0 : cnt + 1'b1;

    // Outputs are decoded from the next state so the registers track the state exactly.
    pwd_next   = (state_next == ST_PWD);
    prst_next  = (state_next == ST_PWD) || (state_next == ST_RST) || (state_next == ST_FAIL);
    sys_next   = (state_next != ST_RUN);
    ready_next = (state_next == ST_RUN);
    fail_next  = (state_next == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PWD;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_pwd   <= 1'b1;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      retry_cnt <= retry_next;
      pll_pwd   <= pwd_next;
      pll_rst   <= prst_next;
      sys_rst   <= sys_next;
      ready     <= ready_next;
      fail      <= fail_next;
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                          loss_cnt <= '0;
    else if (lost && loss_cnt != '1)  loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized lock/restart/rst traffic.
module tb_pll_lock_supervisor;

  localparam int P_PWD = 4;
  localparam int P_RST = 8;
  localparam int P_TO  = 100;
  localparam int P_ST  = 16;
  localparam int P_MAX = 2;

  localparam int SEL_PWD   = 0;
  localparam int SEL_PRST  = 1;
  localparam int SEL_SYS   = 2;
  localparam int SEL_READY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_pwd, pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pll_lock_supervisor #(
    .PWD_CYCLES   (P_PWD),
    .RST_CYCLES   (P_RST),
    .LOCK_TIMEOUT (P_TO),
    .LOCK_STABLE  (P_ST),
    .MAX_RETRY    (P_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_pwd   (pll_pwd),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: named phase with a countdown of remaining cycles.
  string m_phase = "PWD";
  int    m_left  = P_PWD;
  int    m_retry = 0;
  int    m_loss  = 0;
  logic  h1 = 1'b0, h2 = 1'b0;

  task automatic enter(input string name);
    m_phase = name;
    if (name == "PWD")         m_left = P_PWD;
    else if (name == "RST")    m_left = P_RST;
    else if (name == "WAIT")   m_left = P_TO;
    else if (name == "STABLE") m_left = P_ST;
    else                       m_left = 0;
  endtask

  task automatic model_step();
    logic ls;
    ls = h2;
    h2 = h1;
    h1 = pll_lock;
    if (rst) begin
      enter("PWD"); m_retry = 0; m_loss = 0;
    end else if (restart) begin
      enter("PWD"); m_retry = 0;
    end else if (m_phase == "PWD") begin
      m_left--; if (m_left == 0) enter("RST");
    end else if (m_phase == "RST") begin
      m_left--; if (m_left == 0) enter("WAIT");
    end else if (m_phase == "WAIT") begin
      if (ls) enter("STABLE");
      else begin
        m_left--;
        if (m_left == 0) begin
          if (m_retry == P_MAX) enter("FAIL");
          else begin m_retry++; enter("RST"); end
        end
      end
    end else if (m_phase == "STABLE") begin
      if (!ls) enter("WAIT");
      else begin m_left--; if (m_left == 0) enter("RUN"); end
    end else if (m_phase == "RUN") begin
      if (!ls) begin
        enter("RST"); m_retry = 0;
        if (m_loss < 255) m_loss++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SEL_PWD:  return pll_pwd;
      SEL_PRST: return pll_rst;
      SEL_SYS:  return sys_rst;
      default:  return ready;
    endcase
  endfunction

  task automatic run_until(input int sel, input logic val, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sig(sel) !== val && n < bound);
  endtask

  task automatic test_reset();
    rst = 1'b1; restart = 1'b0; pll_lock = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pll_pwd, pll_rst, sys_rst, ready, fail} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 11100", {pll_pwd, pll_rst, sys_rst, ready, fail});
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt);
    end
  endtask

  task automatic test_nominal();
    int n;
    rst = 1'b1; pll_lock = 1'b0; tick(); tick(); rst = 1'b0;
    run_until(SEL_PWD, 1'b0, 50, n);
    checks++;
    if (n != P_PWD) begin errors++; $display("FAIL nominal_pwd_len: got %0d expected %0d", n, P_PWD); end
    run_until(SEL_PRST, 1'b0, 50, n);
    checks++;
    if (n != P_RST) begin errors++; $display("FAIL nominal_rst_len: got %0d expected %0d", n, P_RST); end
    repeat (20) tick();
    pll_lock = 1'b1;
    run_until(SEL_READY, 1'b1, 100, n);
    checks++;
    if (n != 2 + P_ST + 1) begin errors++; $display("FAIL nominal_ready_latency: got %0d expected %0d", n, 2 + P_ST + 1); end
    checks++;
    if (sys_rst !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL nominal_run_outputs: got sys_rst=%b retry=%0d expected 0/0", sys_rst, retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int n, n2;
    pll_lock = 1'b0; tick(); pll_lock = 1'b1;
    run_until(SEL_SYS, 1'b1, 10, n2);
    n = 1 + n2;
    checks++;
    if (n != 3) begin errors++; $display("FAIL loss_sys_rst_latency: got %0d expected 3", n); end
    checks++;
    if (ready !== 1'b0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL loss_outputs: got ready=%b pll_rst=%b expected 0/1", ready, pll_rst);
    end
    run_until(SEL_PRST, 1'b0, 50, n);
    checks++;
    if (n != P_RST) begin errors++; $display("FAIL loss_rst_len: got %0d expected %0d", n, P_RST); end
    run_until(SEL_READY, 1'b1, 100, n);
    checks++;
    if (n != 1 + P_ST) begin errors++; $display("FAIL loss_recover_latency: got %0d expected %0d", n, 1 + P_ST); end
    checks++;
    if (retry_cnt !== 4'd0) begin errors++; $display("FAIL loss_retry: got %0d expected 0", retry_cnt); end
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    checks++;
    if (loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt: got %0d expected 1", loss_cnt); end
`endif
  endtask

  task automatic test_glitch();
    int n;
    int seen_ready = 0;
    pll_lock = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    run_until(SEL_PRST, 1'b0, 50, n);
    pll_lock = 1'b1;
    repeat (10) begin tick(); if (ready === 1'b1) seen_ready++; end
    pll_lock = 1'b0;
    repeat (3) begin tick(); if (ready === 1'b1) seen_ready++; end
    checks++;
    if (seen_ready != 0) begin errors++; $display("FAIL glitch_early_ready: got %0d ready cycles expected 0", seen_ready); end
    pll_lock = 1'b1;
    run_until(SEL_READY, 1'b1, 100, n);
    checks++;
    if (n != 2 + P_ST + 1) begin errors++; $display("FAIL glitch_ready_latency: got %0d expected %0d", n, 2 + P_ST + 1); end
    checks++;
    if (retry_cnt !== 4'd0) begin errors++; $display("FAIL glitch_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_never_lock();
    int n;
    int stuck = 0;
    pll_lock = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    run_until(SEL_PRST, 1'b0, 50, n);
    for (int w = 0; w <= P_MAX; w++) begin
      checks++;
      if (retry_cnt !== 4'(w)) begin errors++; $display("FAIL never_retry_%0d: got %0d expected %0d", w, retry_cnt, w); end
      run_until(SEL_PRST, 1'b1, 200, n);
      checks++;
      if (n != P_TO) begin errors++; $display("FAIL never_window_%0d: got %0d expected %0d", w, n, P_TO); end
      if (w < P_MAX) begin
        run_until(SEL_PRST, 1'b0, 50, n);
        checks++;
        if (n != P_RST) begin errors++; $display("FAIL never_rst_len_%0d: got %0d expected %0d", w, n, P_RST); end
      end
    end
    checks++;
    if ({fail, pll_rst, sys_rst, pll_pwd, ready} !== 5'b11100 || retry_cnt !== 4'(P_MAX)) begin
      errors++;
      $display("FAIL never_fail_state: got fail/prst/sys/pwd/ready=%b retry=%0d expected 11100 retry=%0d",
               {fail, pll_rst, sys_rst, pll_pwd, ready}, retry_cnt, P_MAX);
    end
    repeat (1000) begin
      tick();
      if (fail !== 1'b1 || pll_rst !== 1'b1 || ready !== 1'b0) stuck++;
    end
    checks++;
    if (stuck != 0) begin errors++; $display("FAIL never_fail_hold: got %0d deviating cycles expected 0", stuck); end
  endtask

  task automatic test_restart();
    int n;
    restart = 1'b1; tick(); restart = 1'b0;
    checks++;
    if ({pll_pwd, pll_rst, fail} !== 3'b110 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL restart_from_fail: got pwd/prst/fail=%b retry=%0d expected 110 retry=0", {pll_pwd, pll_rst, fail}, retry_cnt);
    end
    run_until(SEL_PRST, 1'b0, 50, n);
    repeat (30) tick();
    restart = 1'b1; tick(); restart = 1'b0;
    checks++;
    if ({pll_pwd, pll_rst} !== 2'b11) begin
      errors++; $display("FAIL restart_mid_wait: got pwd/prst=%b expected 11", {pll_pwd, pll_rst});
    end
    run_until(SEL_PRST, 1'b0, 50, n);
    run_until(SEL_PRST, 1'b1, 200, n);
    checks++;
    if (retry_cnt !== 4'd1) begin errors++; $display("FAIL restart_first_timeout: got %0d expected 1", retry_cnt); end
    run_until(SEL_PRST, 1'b0, 50, n);
    repeat (P_TO - 1) tick();
    restart = 1'b1; tick(); restart = 1'b0;
    checks++;
    if (pll_pwd !== 1'b1 || retry_cnt !== 4'd0 || fail !== 1'b0) begin
      errors++; $display("FAIL restart_at_timeout: got pwd=%b retry=%0d fail=%b expected 1/0/0", pll_pwd, retry_cnt, fail);
    end
  endtask

  task automatic test_reset_mid_stable();
    int n;
    pll_lock = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    run_until(SEL_PRST, 1'b0, 50, n);
    pll_lock = 1'b1;
    repeat (8) tick();
    checks++;
    if (pll_rst !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL mid_stable_pre: got prst=%b ready=%b expected 0/0", pll_rst, ready);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({pll_pwd, pll_rst, sys_rst, ready, fail} !== 5'b11100 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_stable_reset: got %b retry=%0d expected 11100 retry=0", {pll_pwd, pll_rst, sys_rst, ready, fail}, retry_cnt);
    end
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    checks++;
    if (loss_cnt !== 8'd0) begin errors++; $display("FAIL mid_stable_loss_cnt: got %0d expected 0", loss_cnt); end
`endif
    run_until(SEL_PWD, 1'b0, 50, n);
    checks++;
    if (n != P_PWD) begin errors++; $display("FAIL mid_stable_resequence: got %0d expected %0d", n, P_PWD); end
  endtask

  task automatic test_random();
    int   run_left = 0;
    logic e_pwd, e_prst, e_sys, e_ready, e_fail;
    rst = 1'b1; restart = 1'b0; tick(); rst = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (run_left == 0) begin
        pll_lock = ~pll_lock;
        run_left = pll_lock ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 130));
      end
      run_left--;
      restart = ($urandom_range(0, 399) == 0);
      rst     = ($urandom_range(0, 1499) == 0);
      tick();
      e_pwd   = (m_phase == "PWD");
      e_prst  = (m_phase == "PWD") || (m_phase == "RST") || (m_phase == "FAIL");
      e_sys   = (m_phase != "RUN");
      e_ready = (m_phase == "RUN");
      e_fail  = (m_phase == "FAIL");
      checks++;
      if ({pll_pwd, pll_rst, sys_rst, ready, fail} !== {e_pwd, e_prst, e_sys, e_ready, e_fail} ||
          retry_cnt !== 4'(m_retry)) begin
        errors++;
        $display("FAIL random_c%0d: got pwd/prst/sys/ready/fail=%b retry=%0d expected %b retry=%0d (%s)",
                 c, {pll_pwd, pll_rst, sys_rst, ready, fail}, retry_cnt,
                 {e_pwd, e_prst, e_sys, e_ready, e_fail}, m_retry, m_phase);
      end
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
      checks++;
      if (loss_cnt !== 8'(m_loss)) begin
        errors++; $display("FAIL random_loss_c%0d: got %0d expected %0d", c, loss_cnt, m_loss);
      end
`endif
    end
    rst = 1'b0; restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_glitch();
    test_never_lock();
    test_restart();
    test_reset_mid_stable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
